// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared definitions for the two-requester data-memory arbiter:
//   FSM state encoding and the default first out-of-range byte address.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    localparam logic [31:0] DMEM_ADDR_LIMIT = 32'h0000_0100;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Arbitrates two requesters onto a single combinational-read data memory.
//   One transaction in flight: accept (IDLE) -> memory access (ACCESS) ->
//   hold response until consumed (RESPOND). Two-way round-robin on contention.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_reqN_valid/rwAddress/
//   writeEnable/writeData        request from requester N (held until ready)
//   o_reqN_ready                 request accepted this cycle
//   o_rspN_valid/readData/error  response to requester N
//   i_rspN_ready                 requester N consumes the response
//   o_mem_rwAddress/writeEnable/
//   writeData, i_mem_readData    memory port (valid only during ACCESS)
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = DMEM_ADDR_LIMIT
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_req0_valid,
    input  logic [31:0] i_req0_rwAddress,
    input  logic        i_req0_writeEnable,
    input  logic [31:0] i_req0_writeData,
    output logic        o_req0_ready,
    output logic        o_rsp0_valid,
    output logic [31:0] o_rsp0_readData,
    output logic        o_rsp0_error,
    input  logic        i_rsp0_ready,

    input  logic        i_req1_valid,
    input  logic [31:0] i_req1_rwAddress,
    input  logic        i_req1_writeEnable,
    input  logic [31:0] i_req1_writeData,
    output logic        o_req1_ready,
    output logic        o_rsp1_valid,
    output logic [31:0] o_rsp1_readData,
    output logic        o_rsp1_error,
    input  logic        i_rsp1_ready,

    output logic [31:0] o_mem_rwAddress,
    output logic        o_mem_writeEnable,
    output logic [31:0] o_mem_writeData,
    input  logic [31:0] i_mem_readData
);

    state_t      state;
    logic        ptr;          // requester favoured on contention
    logic        lat_id;
    logic [31:0] lat_addr;
    logic        lat_we;
    logic [31:0] lat_wdata;
    logic [31:0] resp_data;
    logic        resp_err;

    logic        any_req;
    logic        grant_id;
    logic        acc_err;
    logic        rsp_taken;

    always_comb begin
        any_req   = i_req0_valid | i_req1_valid;
        // Both valid: pointer decides; otherwise whichever one is valid.
        grant_id  = (i_req0_valid & i_req1_valid) ? ptr : i_req1_valid;
        acc_err   = (lat_addr[1:0] != 2'b00) || (lat_addr >= ADDR_LIMIT);
        rsp_taken = lat_id ? i_rsp1_ready : i_rsp0_ready;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            ptr       <= 1'b0;
            lat_id    <= 1'b0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        lat_id    <= grant_id;
                        lat_addr  <= grant_id ? i_req1_rwAddress   : i_req0_rwAddress;
                        lat_we    <= grant_id ? i_req1_writeEnable : i_req0_writeEnable;
                        lat_wdata <= grant_id ? i_req1_writeData   : i_req0_writeData;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    resp_err  <= acc_err;
                    resp_data <= (!lat_we && !acc_err) ? i_mem_readData : '0;
                    state     <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    if (rsp_taken) begin
                        ptr   <= ~lat_id;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode registered state; reset masks them in the same cycle so
    // a reset during ACCESS/RESPOND neither writes memory nor hands back data.
    always_comb begin
        o_req0_ready      = 1'b0;
        o_req1_ready      = 1'b0;
        o_rsp0_valid      = 1'b0;
        o_rsp1_valid      = 1'b0;
        o_rsp0_readData   = '0;
        o_rsp1_readData   = '0;
        o_rsp0_error      = 1'b0;
        o_rsp1_error      = 1'b0;
        o_mem_rwAddress   = '0;
        o_mem_writeEnable = 1'b0;
        o_mem_writeData   = '0;
        if (!i_rst) begin
            case (state)
                ST_IDLE: begin
                    o_req0_ready = any_req & ~grant_id;
                    o_req1_ready = any_req &  grant_id;
                end
                ST_ACCESS: begin
                    o_mem_rwAddress   = lat_addr;
                    o_mem_writeData   = lat_wdata;
                    o_mem_writeEnable = lat_we & ~acc_err;
                end
                ST_RESPOND: begin
                    if (lat_id) begin
                        o_rsp1_valid    = 1'b1;
                        o_rsp1_readData = resp_data;
                        o_rsp1_error    = resp_err;
                    end else begin
                        o_rsp0_valid    = 1'b1;
                        o_rsp0_readData = resp_data;
                        o_rsp0_error    = resp_err;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_we, req0_ready, rsp0_valid, rsp0_error, rsp0_ready;
    logic [31:0] req0_addr, req0_wdata, rsp0_data;
    logic        req1_valid, req1_we, req1_ready, rsp1_valid, rsp1_error, rsp1_ready;
    logic [31:0] req1_addr, req1_wdata, rsp1_data;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic [31:0] mem [0:63];
    int          wr_count;
    logic [31:0] last_wr_addr, last_wr_data;
    int          nchecks;
    int          nerrors;

    dmem_arbiter #(.ADDR_LIMIT(32'h0000_0100)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_req0_valid       (req0_valid),
        .i_req0_rwAddress   (req0_addr),
        .i_req0_writeEnable (req0_we),
        .i_req0_writeData   (req0_wdata),
        .o_req0_ready       (req0_ready),
        .o_rsp0_valid       (rsp0_valid),
        .o_rsp0_readData    (rsp0_data),
        .o_rsp0_error       (rsp0_error),
        .i_rsp0_ready       (rsp0_ready),
        .i_req1_valid       (req1_valid),
        .i_req1_rwAddress   (req1_addr),
        .i_req1_writeEnable (req1_we),
        .i_req1_writeData   (req1_wdata),
        .o_req1_ready       (req1_ready),
        .o_rsp1_valid       (rsp1_valid),
        .o_rsp1_readData    (rsp1_data),
        .o_rsp1_error       (rsp1_error),
        .i_rsp1_ready       (rsp1_ready),
        .o_mem_rwAddress    (mem_addr),
        .o_mem_writeEnable  (mem_we),
        .o_mem_writeData    (mem_wdata),
        .i_mem_readData     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            wr_count     <= wr_count + 1;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_wdata;
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs;
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0; rsp0_ready = 0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0; rsp1_ready = 0;
    endtask

    initial begin
        int base_wr;
        logic exp_r0, exp_r1;
        nchecks  = 0;
        nerrors  = 0;
        wr_count = 0;
        last_wr_addr = '0;
        last_wr_data = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[3]  = 32'hDEAD_BEEF;
        mem[4]  = 32'h1111_0000;
        mem[5]  = 32'h2222_0001;
        mem[63] = 32'hCAFE_0001;

        // ---------------- reset, with a request pending ----------------
        idle_inputs();
        rst = 1;
        req0_valid = 1; req0_addr = 32'h0C;
        tick(); tick();
        settle();
        chk("rst_ready0", {31'b0, req0_ready}, 32'h0);
        chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        req0_valid = 0;
        rst = 0;
        tick();

        // ---------------- contention: grants 0,1,0,1 every 3 cycles ----------------
        req0_valid = 1; req0_addr = 32'h10;
        req1_valid = 1; req1_addr = 32'h14;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int k = 0; k < 12; k++) begin
            settle();
            exp_r0 = (k % 3 == 0) && ((k / 3) % 2 == 0);
            exp_r1 = (k % 3 == 0) && ((k / 3) % 2 == 1);
            chk($sformatf("cont_ready0_k%0d", k), {31'b0, req0_ready}, {31'b0, exp_r0});
            chk($sformatf("cont_ready1_k%0d", k), {31'b0, req1_ready}, {31'b0, exp_r1});
            if (k % 3 == 2) begin
                if ((k / 3) % 2 == 0) begin
                    chk("cont_rsp0_valid", {31'b0, rsp0_valid}, 32'h1);
                    chk("cont_rsp0_data", rsp0_data, 32'h1111_0000);
                end else begin
                    chk("cont_rsp1_valid", {31'b0, rsp1_valid}, 32'h1);
                    chk("cont_rsp1_data", rsp1_data, 32'h2222_0001);
                end
            end
            tick();
        end
        idle_inputs();
        settle();

        // ---------------- single load of word 3 ----------------
        req0_valid = 1; req0_addr = 32'h0C; req0_we = 0;
        settle();
        chk("ld_ready0_T", {31'b0, req0_ready}, 32'h1);
        chk("ld_ready1_T", {31'b0, req1_ready}, 32'h0);
        chk("ld_mem_addr_idle", mem_addr, 32'h0);
        tick();
        req0_valid = 0;
        settle();
        chk("ld_ready0_T1", {31'b0, req0_ready}, 32'h0);
        chk("ld_mem_addr_T1", mem_addr, 32'h0C);
        chk("ld_mem_we_T1", {31'b0, mem_we}, 32'h0);
        chk("ld_rsp0_valid_T1", {31'b0, rsp0_valid}, 32'h0);
        tick();
        settle();
        chk("ld_rsp0_valid_T2", {31'b0, rsp0_valid}, 32'h1);
        chk("ld_rsp0_data", rsp0_data, 32'hDEAD_BEEF);
        chk("ld_rsp0_error", {31'b0, rsp0_error}, 32'h0);
        chk("ld_rsp1_valid", {31'b0, rsp1_valid}, 32'h0);
        chk("ld_mem_addr_T2", mem_addr, 32'h0);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        settle();
        chk("ld_rsp0_valid_done", {31'b0, rsp0_valid}, 32'h0);

        // ---------------- misaligned store from req1 ----------------
        base_wr = wr_count;
        req1_valid = 1; req1_addr = 32'h06; req1_we = 1; req1_wdata = 32'h1234;
        settle();
        chk("mis_ready1", {31'b0, req1_ready}, 32'h1);
        tick();
        idle_inputs();
        settle();
        chk("mis_mem_we", {31'b0, mem_we}, 32'h0);
        tick();
        settle();
        chk("mis_rsp1_valid", {31'b0, rsp1_valid}, 32'h1);
        chk("mis_rsp1_error", {31'b0, rsp1_error}, 32'h1);
        chk("mis_rsp1_data", rsp1_data, 32'h0);
        rsp1_ready = 1;
        tick();
        rsp1_ready = 0;
        chk("mis_no_write", wr_count, base_wr);

        // ---------------- out of range / last valid word ----------------
        req0_valid = 1; req0_addr = 32'h100;
        tick();
        req0_valid = 0;
        tick();
        settle();
        chk("oor_rsp0_error", {31'b0, rsp0_error}, 32'h1);
        chk("oor_rsp0_data", rsp0_data, 32'h0);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        req0_valid = 1; req0_addr = 32'hFC;
        tick();
        req0_valid = 0;
        tick();
        settle();
        chk("top_rsp0_error", {31'b0, rsp0_error}, 32'h0);
        chk("top_rsp0_data", rsp0_data, 32'hCAFE_0001);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;

        // ---------------- legal store ----------------
        base_wr = wr_count;
        req0_valid = 1; req0_addr = 32'h20; req0_we = 1; req0_wdata = 32'hA5A5_0F0F;
        tick();
        idle_inputs();
        settle();
        chk("st_mem_we", {31'b0, mem_we}, 32'h1);
        chk("st_mem_wdata", mem_wdata, 32'hA5A5_0F0F);
        tick();
        chk("st_write_count", wr_count, base_wr + 1);
        chk("st_write_addr", last_wr_addr, 32'h20);
        settle();
        chk("st_rsp0_data", rsp0_data, 32'h0);
        chk("st_rsp0_error", {31'b0, rsp0_error}, 32'h0);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;

        // ---------------- backpressure on rsp0 ----------------
        req0_valid = 1; req0_addr = 32'h0C; req0_we = 0;
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_addr = 32'h14; req1_we = 0;
        tick();
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("bp_rsp0_valid_%0d", k), {31'b0, rsp0_valid}, 32'h1);
            chk($sformatf("bp_rsp0_data_%0d", k), rsp0_data, 32'hDEAD_BEEF);
            chk($sformatf("bp_ready1_%0d", k), {31'b0, req1_ready}, 32'h0);
            tick();
        end
        rsp0_ready = 1;
        settle();
        chk("bp_ready1_xfer", {31'b0, req1_ready}, 32'h0);
        tick();
        rsp0_ready = 0;
        settle();
        chk("bp_rsp0_valid_after", {31'b0, rsp0_valid}, 32'h0);
        chk("bp_ready1_after", {31'b0, req1_ready}, 32'h1);
        tick();
        req1_valid = 0;
        tick();
        settle();
        chk("bp_rsp1_data", rsp1_data, 32'h2222_0001);
        rsp1_ready = 1;
        tick();
        rsp1_ready = 0;

        // ---------------- reset during ACCESS of a store ----------------
        // req0 completes first so the pointer moves to 1
        req0_valid = 1; req0_addr = 32'h10; req0_we = 0;
        tick();
        req0_valid = 0;
        tick();
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        base_wr = wr_count;
        req0_valid = 1; req0_addr = 32'h24; req0_we = 1; req0_wdata = 32'h5555_AAAA;
        tick();
        idle_inputs();
        rst = 1;
        settle();
        chk("rs_mem_we", {31'b0, mem_we}, 32'h0);
        tick();
        rst = 0;
        settle();
        chk("rs_no_write", wr_count, base_wr);
        chk("rs_mem_addr", mem_addr, 32'h0);
        chk("rs_rsp0_valid", {31'b0, rsp0_valid}, 32'h0);
        tick();
        settle();
        chk("rs_rsp0_valid_late", {31'b0, rsp0_valid}, 32'h0);
        req0_valid = 1; req1_valid = 1; req0_addr = 32'h10; req1_addr = 32'h14;
        settle();
        chk("rs_ptr_ready0", {31'b0, req0_ready}, 32'h1);
        chk("rs_ptr_ready1", {31'b0, req1_ready}, 32'h0);
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
